// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the EX-stage forwarding/hazard controller.
package fwd_hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] FWD_SEL_RF    = 3'd0;
  localparam logic [SEL_W-1:0] FWD_SEL_EXMEM = 3'd1;
  localparam logic [SEL_W-1:0] FWD_SEL_MEMWB = 3'd2;
  localparam logic [SEL_W-1:0] FWD_SEL_RSVD  = 3'd3;

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic              is_load;
  } stage_t;

  typedef enum logic {StRun, StStall} ctrl_st_e;

  // GPR $0 is hardwired to zero, so it never produces a hazard.
  function automatic logic hz_match(stage_t s, logic [REG_AW-1:0] r);
    return s.valid & s.wr_en & (s.wr_addr == r) & (r != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-side request and forwarding/stall response bundle of the hazard controller.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import fwd_hazard_ctrl_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_addr;
  logic              id_is_load;
  logic              flush;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic              stall;
  logic              bubble;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_wr_addr, id_is_load,
           flush,
    input  fwd_a_sel, fwd_b_sel, stall, bubble, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_wr_addr, id_is_load,
           flush,
    output fwd_a_sel, fwd_b_sel, stall, bubble, stall_cnt
  );

endinterface

// File: rtl/fwd_stage_reg.sv
// One shadow pipeline stage record; clr_i loads an empty (bubble) record.
module fwd_stage_reg
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = clr_i ? '0 : d_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Registered EX operand forwarding selects plus load-use stall/bubble control
// for a 5-stage MIPS pipeline, using its own EX/MEM/WB destination shadow.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_ctrl_if.slave bus
);

  stage_t   id_stage, ex_q, mem_q, wb_q;
  ctrl_st_e st_d, st_q;
  logic     load_use, stall, bubble;

  logic [SEL_W-1:0] sel_a_d, sel_a_q, sel_b_d, sel_b_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  function automatic logic [SEL_W-1:0] next_sel(stage_t ex, stage_t mem, logic [REG_AW-1:0] r);
    if (hz_match(ex, r) && !ex.is_load) return FWD_SEL_EXMEM;
    if (hz_match(mem, r))               return FWD_SEL_MEMWB;
    return FWD_SEL_RF;
  endfunction

  assign id_stage = '{valid:   bus.id_valid,
                      wr_en:   bus.id_wr_en,
                      wr_addr: bus.id_wr_addr,
                      is_load: bus.id_is_load};

  fwd_stage_reg u_ex  (.clk(clk), .rst(rst), .clr_i(bubble), .d_i(id_stage), .q_o(ex_q));
  fwd_stage_reg u_mem (.clk(clk), .rst(rst), .clr_i(1'b0),   .d_i(ex_q),     .q_o(mem_q));
  fwd_stage_reg u_wb  (.clk(clk), .rst(rst), .clr_i(1'b0),   .d_i(mem_q),    .q_o(wb_q));

  // Register file writes in the first half-cycle, so WB never needs a forward.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  assign load_use = bus.id_valid & ex_q.is_load &
                    ((bus.id_uses_rs & hz_match(ex_q, bus.id_rs)) |
                     (bus.id_uses_rt & hz_match(ex_q, bus.id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= StRun;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StRun:   if (!bus.flush && load_use) st_d = StStall;
      StStall: st_d = StRun;
      default: st_d = StRun;
    endcase
  end

  // Flush wins over a simultaneous load-use.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    if (bus.flush) begin
      bubble = 1'b1;
    end else if (st_q == StRun && load_use) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  always_comb begin
    sel_a_d = FWD_SEL_RF;
    sel_b_d = FWD_SEL_RF;
    if (bus.id_valid && !bubble) begin
      sel_a_d = next_sel(ex_q, mem_q, bus.id_rs);
      sel_b_d = next_sel(ex_q, mem_q, bus.id_rt);
    end
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_a_q <= FWD_SEL_RF;
      sel_b_q <= FWD_SEL_RF;
      cnt_q   <= '0;
    end else begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.fwd_a_sel = sel_a_q;
  assign bus.fwd_b_sel = sel_b_q;
  assign bus.stall     = stall;
  assign bus.bubble    = bubble;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; a second narrow-counter instance sees the
// same stimulus so counter saturation is reachable in a few stalls.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.CNT_W(16)) bus ();
  fwd_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

  fwd_hazard_ctrl #(.CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bus.slave));
  fwd_hazard_ctrl #(.CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bus2.slave));

  assign bus2.id_valid   = bus.id_valid;
  assign bus2.id_rs      = bus.id_rs;
  assign bus2.id_rt      = bus.id_rt;
  assign bus2.id_uses_rs = bus.id_uses_rs;
  assign bus2.id_uses_rt = bus.id_uses_rt;
  assign bus2.id_wr_en   = bus.id_wr_en;
  assign bus2.id_wr_addr = bus.id_wr_addr;
  assign bus2.id_is_load = bus.id_is_load;
  assign bus2.flush      = bus.flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic wen,
                     input logic [4:0] wa, input logic ld, input logic fl);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_wr_en   = wen;
    bus.id_wr_addr = wa;
    bus.id_is_load = ld;
    bus.flush      = fl;
  endtask

  task automatic alu(input logic [4:0] wa, input logic [4:0] rs, input logic [4:0] rt);
    drv(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, wa, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] wa, input logic [4:0] rs);
    drv(1'b1, rs, 5'd0, 1'b1, 1'b0, 1'b1, wa, 1'b1, 1'b0);
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nop();
    #1;
    chk("rst_sel_a", 32'(bus.fwd_a_sel), 0);
    chk("rst_sel_b", 32'(bus.fwd_b_sel), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_bubble", 32'(bus.bubble), 0);
    chk("rst_cnt", 32'(bus.stall_cnt), 0);
    tick();
    rst = 1'b0;
    tick();

    // add $3,$1,$2 ; sub $4,$3,$5
    alu(5'd3, 5'd1, 5'd2); tick();
    alu(5'd4, 5'd3, 5'd5); #1;
    chk("chain_stall", 32'(bus.stall), 0);
    tick();
    chk("chain_sel_a", 32'(bus.fwd_a_sel), 1);
    chk("chain_sel_b", 32'(bus.fwd_b_sel), 0);
    nop(); tick(); tick();

    // add $3 ; nop ; or $6,$3,$3
    alu(5'd3, 5'd1, 5'd2); tick();
    nop(); tick();
    alu(5'd6, 5'd3, 5'd3); tick();
    chk("dist2_sel_a", 32'(bus.fwd_a_sel), 2);
    chk("dist2_sel_b", 32'(bus.fwd_b_sel), 2);
    nop(); tick(); tick();

    // add $3 ; add $3,$3,$1 ; add $8,$3,$3
    alu(5'd3, 5'd1, 5'd2); tick();
    alu(5'd3, 5'd3, 5'd1); tick();
    chk("mid_sel_a", 32'(bus.fwd_a_sel), 1);
    chk("mid_sel_b", 32'(bus.fwd_b_sel), 0);
    alu(5'd8, 5'd3, 5'd3); tick();
    chk("newest_sel_a", 32'(bus.fwd_a_sel), 1);
    chk("newest_sel_b", 32'(bus.fwd_b_sel), 1);
    nop(); tick(); tick();

    // lw $2 ; add $7,$2,$1
    chk("lu_cnt0", 32'(bus.stall_cnt), 0);
    lw(5'd2, 5'd9); tick();
    alu(5'd7, 5'd2, 5'd1); #1;
    chk("lu_stall", 32'(bus.stall), 1);
    chk("lu_bubble", 32'(bus.bubble), 1);
    tick();
    chk("lu_bub_sel_a", 32'(bus.fwd_a_sel), 0);
    chk("lu_cnt1", 32'(bus.stall_cnt), 1);
    #1;
    chk("lu_stall_2nd", 32'(bus.stall), 0);
    chk("lu_bubble_2nd", 32'(bus.bubble), 0);
    tick();
    chk("lu_sel_a", 32'(bus.fwd_a_sel), 2);
    chk("lu_sel_b", 32'(bus.fwd_b_sel), 0);
    nop(); tick(); tick();

    // addi $0 ; use $0 ; lw $0 ; use $0
    alu(5'd0, 5'd1, 5'd0); tick();
    alu(5'd10, 5'd0, 5'd0); tick();
    chk("r0_sel_a", 32'(bus.fwd_a_sel), 0);
    chk("r0_sel_b", 32'(bus.fwd_b_sel), 0);
    lw(5'd0, 5'd1); tick();
    alu(5'd11, 5'd0, 5'd0); #1;
    chk("r0_lw_stall", 32'(bus.stall), 0);
    tick();
    chk("r0_lw_sel_a", 32'(bus.fwd_a_sel), 0);
    chk("r0_lw_sel_b", 32'(bus.fwd_b_sel), 0);
    nop(); tick(); tick();

    // flush together with load-use
    lw(5'd2, 5'd9); tick();
    drv(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1); #1;
    chk("fl_stall", 32'(bus.stall), 0);
    chk("fl_bubble", 32'(bus.bubble), 1);
    tick();
    chk("fl_sel_a", 32'(bus.fwd_a_sel), 0);
    chk("fl_cnt", 32'(bus.stall_cnt), 1);
    nop(); #1;
    chk("fl_after_stall", 32'(bus.stall), 0);
    tick(); tick();

    // reset asserted mid-stall
    lw(5'd2, 5'd9); tick();
    alu(5'd7, 5'd2, 5'd1); #1;
    chk("rs_stall_pre", 32'(bus.stall), 1);
    rst = 1'b1; #1;
    chk("rs_stall", 32'(bus.stall), 0);
    chk("rs_bubble", 32'(bus.bubble), 0);
    chk("rs_cnt", 32'(bus.stall_cnt), 0);
    chk("rs_sel_a", 32'(bus.fwd_a_sel), 0);
    tick();
    rst = 1'b0; #1;
    chk("rs_rel_stall", 32'(bus.stall), 0);
    tick();
    chk("rs_rel_sel_a", 32'(bus.fwd_a_sel), 0);
    chk("rs_rel_sel_b", 32'(bus.fwd_b_sel), 0);
    nop(); tick(); tick();

    // repeated load-use: 16-bit count keeps going, 2-bit count sticks at 3
    for (int i = 0; i < 4; i++) begin
      lw(5'd2, 5'd9); tick();
      alu(5'd7, 5'd2, 5'd1); tick(); tick();
      nop(); tick();
      chk("sat_cnt_main", 32'(bus.stall_cnt), 32'(i + 1));
      chk("sat_cnt_small", 32'(bus2.stall_cnt), (i >= 2) ? 32'd3 : 32'(i + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
